// File: rtl/latch_rr_arbiter.sv
// Round-robin arbiter that shares one registered bit q among N requesters.
// The owner's data bit loads q each granted cycle; owners are preempted after MAX_HOLD cycles under contention.
module latch_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 q
);

  localparam int W  = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic         found;
    logic [W-1:0] idx;
  } pick_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  last;
  logic [N-1:0]  others;
  pick_t         pick_any;
  pick_t         pick_other;

  // First set bit of v scanning ptr+1, ptr+2, ... mod N; descending loop lets the nearest win.
  function automatic pick_t rr_pick(input logic [N-1:0] v, input logic [W-1:0] ptr);
    pick_t p;
    int    j;
    p = '0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(ptr) + i) % N;
      if (v[W'(j)]) begin
        p.found = 1'b1;
        p.idx   = W'(j);
      end
    end
    return p;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    return N'(1) << idx;
  endfunction

  // NOTE: every always_comb output gets a full default before any partial update, so no latch is inferred.
  always_comb begin
    others        = req;
    others[owner] = 1'b0;
    pick_any      = rr_pick(req, last);
    pick_other    = rr_pick(others, last);
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      busy  <= 1'b0;
      q     <= 1'b0;
      cnt   <= '0;
      last  <= W'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_any.found) begin
            state <= GRANT;
            gnt   <= onehot(pick_any.idx);
            owner <= pick_any.idx;
            busy  <= 1'b1;
            last  <= pick_any.idx;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            // Release wins over hold expiry and never loads q.
            if (pick_other.found) begin
              gnt   <= onehot(pick_other.idx);
              owner <= pick_other.idx;
              last  <= pick_other.idx;
              cnt   <= '0;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end else if (cnt == HOLD_LAST && pick_other.found) begin
            q     <= data[owner];
            gnt   <= onehot(pick_other.idx);
            owner <= pick_other.idx;
            last  <= pick_other.idx;
            cnt   <= '0;
          end else begin
            q <= data[owner];
            if (cnt != HOLD_LAST) cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_rr_arbiter.sv
// Scoreboard bench for latch_rr_arbiter (N=4, MAX_HOLD=4): the driver queues hand-computed
// post-edge expectations, and a monitor pops and compares them one per clock edge.
module tb_latch_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       q;
    string      tag;
  } exp_t;

  exp_t sb[$];

  latch_rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .owner(owner),
    .busy (busy),
    .q    (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the coming rising edge.
  task automatic step(input logic rst_v, input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] eg, input logic eq, input string tag);
    exp_t e;
    @(negedge clk);
    reset = rst_v;
    req   = r;
    data  = d;
    e.gnt = eg;
    e.q   = eq;
    e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   k;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " gnt"},  {4'b0, gnt},  {4'b0, e.gnt});
        check({e.tag, " busy"}, {7'b0, busy}, {7'b0, |e.gnt});
        check({e.tag, " q"},    {7'b0, q},    {7'b0, e.q});
        if (e.gnt != 4'b0000) begin
          k = 0;
          for (int i = 0; i < 4; i++) if (e.gnt[i]) k = i;
          check({e.tag, " owner"}, {6'b0, owner}, 8'(k));
        end
      end
    end
  end

  initial begin : driver
    logic t;
    reset = 1'b0;
    req   = 4'b0000;
    data  = 4'b0000;

    // Reset dominates full requests; first arbitration after release picks index 0.
    repeat (3) step(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, "reset_hold");
    step(1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b0, "reset_release");

    // Continuous contention: each owner holds exactly 4 cycles; data = 1010.
    repeat (3) step(1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b0, "rr_own0");
    step(1'b1, 4'b1111, 4'b1010, 4'b0010, 1'b0, "rr_pre1");
    repeat (3) step(1'b1, 4'b1111, 4'b1010, 4'b0010, 1'b1, "rr_own1");
    step(1'b1, 4'b1111, 4'b1010, 4'b0100, 1'b1, "rr_pre2");
    repeat (3) step(1'b1, 4'b1111, 4'b1010, 4'b0100, 1'b0, "rr_own2");
    step(1'b1, 4'b1111, 4'b1010, 4'b1000, 1'b0, "rr_pre3");
    repeat (3) step(1'b1, 4'b1111, 4'b1010, 4'b1000, 1'b1, "rr_own3");
    step(1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b1, "rr_wrap0");
    step(1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b0, "rr_own0b");

    // Owner 0 releases with req[3] pending: direct handoff, q not loaded from data[0]=1.
    step(1'b1, 4'b1000, 4'b0001, 4'b1000, 1'b0, "handoff");
    step(1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b1, "handoff_load");

    // Owner 3 releases to 2; then a lone owner keeps the grant and q tracks data[2] by one cycle.
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1, "single_take");
    for (int i = 1; i <= 10; i++) begin
      t = 1'(i & 1);
      step(1'b1, 4'b0100, {1'b0, t, 2'b00}, 4'b0100, t, "single_hold");
    end

    // Owner 2 sits at the last hold count and releases with nobody waiting: IDLE, q unchanged.
    step(1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0, "release_idle");
    step(1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, "idle_hold_q");

    // Pointer was left at 2, so 0011 picks 0 before 1.
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b0, "idle_rr_pick");
    step(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, "to_owner1");
    step(1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, "owner1_load");

    // Reset mid-grant clears q and restores the pointer, so 1010 picks 1 rather than 3.
    step(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, "reset_mid");
    step(1'b1, 4'b1010, 4'b0000, 4'b0010, 1'b0, "post_reset_pick");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
